gravity_scheduler: RTL and testbench
====================================

Name: gravity_scheduler

Overview:
- Consumes the 60 Hz one-cycle frame-tick pulse from the frame-rate tick generator.
- Counts frames and issues piece-drop requests to the game-control FSM over a req/ack handshake.
- Drop interval comes from a per-level speed table. It is shortened while soft drop is held.
- Drops the control FSM fails to acknowledge in time are counted as missed.

Parameters:
FRAME_W, 6, width of frame counter (must hold max table value 48)
MISS_W, 4, width of saturating missed-drop counter
SOFT_FRAMES, 2, frames per drop while soft_drop is held

Ports:
clk  input  1  system clock (50 MHz)
resetn  input  1  reset: reset resetn, synchronous, active-low; clock clk
frame_tick  input  1  one-cycle pulse, once per 1/60 s
enable  input  1  game running; low = paused/idle
restart  input  1  one-cycle pulse on piece spawn; restarts interval
level  input  4  current level, 0..15
soft_drop  input  1  down key held
drop_ack  input  1  control FSM accepted the drop (one-cycle pulse)
drop_req  output  1  drop request, held until acknowledged
frame_cnt  output  FRAME_W  frames elapsed in current interval
missed  output  MISS_W  saturating count of overrun intervals

Behaviour:
- Reset (resetn low at a clk edge): state=IDLE; drop_req=0; frame_cnt=0; missed=0. Reset overrides everything.
- Speed table, frames per drop for levels 0..9: 48,43,38,33,28,23,18,13,8,6. Levels 10..15 use 6.
- thr = soft_drop ? min(table[level], SOFT_FRAMES) : table[level].
- thr is evaluated combinationally every cycle. A level or soft_drop change takes effect on the next frame_tick.
- Priority order: reset > enable low > restart > drop_ack/frame_tick.
- States: IDLE, COUNT, REQ.
- IDLE:
  - drop_req=0; frame_cnt held at 0; missed held.
  - Goes to COUNT on the first cycle enable=1.
- enable low in any state: go to IDLE next cycle, drop_req=0, frame_cnt=0. A pending request is abandoned, not counted as missed.
- restart (enable high):
  - frame_cnt=0, drop_req=0, missed=0, state=COUNT next cycle.
  - A frame_tick or drop_ack in the same cycle is ignored.
- COUNT, on frame_tick:
  - If frame_cnt+1 >= thr: frame_cnt=0, drop_req=1, state=REQ.
  - Otherwise frame_cnt increments.
  - The compare uses >=, so lowering thr below the current count fires on the next tick.
  - Latency: tick at cycle N gives drop_req=1 at N+1.
- REQ:
  - drop_req stays 1 and frame_cnt keeps counting ticks.
  - Threshold reached with no ack in the same cycle: frame_cnt=0, missed increments (saturates at 2^MISS_W-1), stay REQ.
  - drop_ack with no threshold hit: drop_req=0 next cycle, state=COUNT. frame_cnt is not cleared.
  - drop_ack in the same cycle as a threshold hit: the current request is retired and a new one is issued. drop_req stays 1, frame_cnt=0, state stays REQ, missed unchanged.
- drop_ack in IDLE or COUNT is ignored.
- frame_cnt never exceeds thr-1 after any tick.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package tetris_timing_pkg holds:
  - state encoding constants (IDLE/COUNT/REQ);
  - FRAMES_PER_SEC=60;
  - the 10-entry speed table and its clamp value 6.
- One sub-module, gravity_speed_lut: combinational level+soft_drop -> thr, FRAME_W wide.
- The FSM and counters stay in gravity_scheduler.

Test Plan:
- Reset then enable=1, level=0, 48 frame_ticks, ack 3 cycles after req -> drop_req rises the cycle after the 48th tick; frame_cnt=0; drop_req falls the cycle after ack; missed=0.
- level=9, no ack, 18 ticks -> req after tick 6 and held; missed=1 after tick 12 and 2 after tick 18; frame_cnt=0 after each.
- level=0, 10 ticks, then soft_drop=1 -> next tick fires req (10+1 >= 2); then with acks, req every 2 ticks.
- level=5 in REQ, drop_ack and the threshold-reaching tick in the same cycle -> drop_req stays 1, missed unchanged, frame_cnt=0.
- restart pulse while in REQ with missed=3 -> next cycle drop_req=0, missed=0, frame_cnt=0, state COUNT; a simultaneous tick is not counted.
- Mid-REQ, enable=0 for 5 cycles with ticks, then resetn=0 for 1 cycle -> IDLE, drop_req=0, frame_cnt=0, missed=0. 60 ticks at level 15 yield exactly 10 reqs when each is acked.

Source files
------------

// File: rtl/tetris_timing_pkg.sv
// Shared frame-timing definitions: FSM state encoding, frame rate and the
// per-level gravity speed table (frames per drop).
package tetris_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } state_t;

  localparam int FRAMES_PER_SEC = 60;
  localparam int SPEED_LEVELS   = 10;
  localparam logic [7:0] SPEED_CLAMP = 8'd6;

  localparam logic [7:0] SPEED_TABLE [0:SPEED_LEVELS-1] = '{
    8'd48, 8'd43, 8'd38, 8'd33, 8'd28, 8'd23, 8'd18, 8'd13, 8'd8, 8'd6
  };

  // Levels past the end of the table all run at the clamp speed.
  function automatic logic [7:0] speed_frames(input logic [3:0] level);
    if (level < 4'(SPEED_LEVELS)) begin
      return SPEED_TABLE[level];
    end
    return SPEED_CLAMP;
  endfunction

endpackage

// File: rtl/gravity_speed_lut.sv
// Level + soft-drop to frames-per-drop threshold.
// Purely combinational; no state, no backpressure.
module gravity_speed_lut
  import tetris_timing_pkg::*;
#(
  parameter int FRAME_W     = 6,
  parameter int SOFT_FRAMES = 2
) (
  input  logic [3:0]         level,
  input  logic               soft_drop,
  output logic [FRAME_W-1:0] thr
);

  logic [FRAME_W-1:0] base;

  always_comb begin
    base = FRAME_W'(speed_frames(level));
    thr  = base;
    // Soft drop can only speed gravity up, never slow a fast level down.
    if (soft_drop && (base > FRAME_W'(SOFT_FRAMES))) begin
      thr = FRAME_W'(SOFT_FRAMES);
    end
  end

endmodule

// File: rtl/gravity_scheduler.sv
// Frame-tick driven gravity: issues drop_req every thr frames and counts overruns.
// Latency: tick -> drop_req one cycle; drop_req held until drop_ack, overruns counted in missed.
module gravity_scheduler
  import tetris_timing_pkg::*;
#(
  parameter int FRAME_W     = 6,
  parameter int MISS_W      = 4,
  parameter int SOFT_FRAMES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               restart,
  input  logic [3:0]         level,
  input  logic               soft_drop,
  input  logic               drop_ack,
  output logic               drop_req,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [MISS_W-1:0]  missed
);

  state_t             state, state_nxt;
  logic               req_nxt;
  logic [FRAME_W-1:0] cnt_nxt;
  logic [MISS_W-1:0]  miss_nxt;
  logic [FRAME_W-1:0] thr;
  logic [FRAME_W:0]   cnt_inc;
  logic               hit;

  gravity_speed_lut #(
    .FRAME_W    (FRAME_W),
    .SOFT_FRAMES(SOFT_FRAMES)
  ) u_lut (
    .level    (level),
    .soft_drop(soft_drop),
    .thr      (thr)
  );

  // Extra bit so the increment cannot wrap before the compare.
  assign cnt_inc = {1'b0, frame_cnt} + (FRAME_W+1)'(1);
  assign hit     = frame_tick && (cnt_inc >= {1'b0, thr});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      drop_req  <= 1'b0;
      frame_cnt <= '0;
      missed    <= '0;
    end else begin
      state     <= state_nxt;
      drop_req  <= req_nxt;
      frame_cnt <= cnt_nxt;
      missed    <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = drop_req;
    cnt_nxt   = frame_cnt;
    miss_nxt  = missed;
    if (!enable) begin
      state_nxt = IDLE;
      req_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else if (restart) begin
      state_nxt = COUNT;
      req_nxt   = 1'b0;
      cnt_nxt   = '0;
      miss_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = COUNT;
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
        COUNT: begin
          if (hit) begin
            state_nxt = REQ;
            req_nxt   = 1'b1;
            cnt_nxt   = '0;
          end else if (frame_tick) begin
            cnt_nxt = cnt_inc[FRAME_W-1:0];
          end
        end
        REQ: begin
          if (hit) begin
            // An ack on the same cycle retires the old request; a new one is issued.
            req_nxt = 1'b1;
            cnt_nxt = '0;
            if (!drop_ack && (missed != '1)) begin
              miss_nxt = missed + MISS_W'(1);
            end
          end else begin
            if (frame_tick) begin
              cnt_nxt = cnt_inc[FRAME_W-1:0];
            end
            if (drop_ack) begin
              state_nxt = COUNT;
              req_nxt   = 1'b0;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gravity_scheduler.sv
// Directed bench for gravity_scheduler; expected values are hand-derived from the speed table.
module tb_gravity_scheduler;

  localparam int FRAME_W = 6;
  localparam int MISS_W  = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic               frame_tick;
  logic               enable;
  logic               restart;
  logic [3:0]         level;
  logic               soft_drop;
  logic               drop_ack;
  logic               drop_req;
  logic [FRAME_W-1:0] frame_cnt;
  logic [MISS_W-1:0]  missed;

  int checks = 0;
  int fails  = 0;
  int reqs   = 0;

  gravity_scheduler #(
    .FRAME_W    (FRAME_W),
    .MISS_W     (MISS_W),
    .SOFT_FRAMES(2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .frame_tick(frame_tick),
    .enable    (enable),
    .restart   (restart),
    .level     (level),
    .soft_drop (soft_drop),
    .drop_ack  (drop_ack),
    .drop_req  (drop_req),
    .frame_cnt (frame_cnt),
    .missed    (missed)
  );

  always #5 clk = ~clk;

  // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic t, input logic a, input logic r);
    frame_tick = t;
    drop_ack   = a;
    restart    = r;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    drop_ack   = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; level = 4'd0; soft_drop = 1'b0;
    frame_tick = 1'b0; drop_ack = 1'b0; restart = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_req", 32'(drop_req), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    chk("rst_miss", 32'(missed), 0);

    // Level 0: 48 frames per drop, ack three cycles after the request.
    resetn = 1'b1; enable = 1'b1;
    step(0, 0, 0);
    ticks(47);
    chk("l0_cnt47", 32'(frame_cnt), 47);
    chk("l0_noreq", 32'(drop_req), 0);
    ticks(1);
    chk("l0_req", 32'(drop_req), 1);
    chk("l0_cnt0", 32'(frame_cnt), 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("l0_ackreq", 32'(drop_req), 0);
    chk("l0_miss", 32'(missed), 0);

    // drop_ack while counting is ignored.
    ticks(1);
    step(0, 1, 0);
    chk("cnt_ack_cnt", 32'(frame_cnt), 1);
    chk("cnt_ack_req", 32'(drop_req), 0);

    // Level 9 (6 frames), no acks: one request then overruns every 6 ticks.
    level = 4'd9;
    step(0, 0, 1);
    ticks(5);
    chk("l9_noreq5", 32'(drop_req), 0);
    ticks(1);
    chk("l9_req6", 32'(drop_req), 1);
    ticks(6);
    chk("l9_miss12", 32'(missed), 1);
    chk("l9_cnt12", 32'(frame_cnt), 0);
    chk("l9_req12", 32'(drop_req), 1);
    ticks(6);
    chk("l9_miss18", 32'(missed), 2);
    chk("l9_cnt18", 32'(frame_cnt), 0);
    ticks(6);
    chk("l9_miss24", 32'(missed), 3);

    // Restart in REQ with a simultaneous tick: tick is dropped, missed cleared.
    step(1, 0, 1);
    chk("rs_req", 32'(drop_req), 0);
    chk("rs_miss", 32'(missed), 0);
    chk("rs_cnt", 32'(frame_cnt), 0);
    ticks(1);
    chk("rs_count", 32'(frame_cnt), 1);
    chk("rs_state", 32'(drop_req), 0);

    // Level 0, 10 frames counted, then soft drop lowers thr to 2.
    level = 4'd0;
    step(0, 0, 1);
    ticks(10);
    chk("sd_cnt10", 32'(frame_cnt), 10);
    soft_drop = 1'b1;
    ticks(1);
    chk("sd_req", 32'(drop_req), 1);
    chk("sd_cnt0", 32'(frame_cnt), 0);
    step(0, 1, 0);
    ticks(1);
    chk("sd_t1", 32'(drop_req), 0);
    ticks(1);
    chk("sd_t2", 32'(drop_req), 1);
    soft_drop = 1'b0;
    step(0, 1, 0);
    chk("sd_ack", 32'(drop_req), 0);

    // Level 5 (23 frames): ack lands on the threshold tick.
    level = 4'd5;
    ticks(23);
    chk("l5_req", 32'(drop_req), 1);
    ticks(22);
    chk("l5_cnt22", 32'(frame_cnt), 22);
    step(1, 1, 0);
    chk("l5_hitack_req", 32'(drop_req), 1);
    chk("l5_hitack_miss", 32'(missed), 0);
    chk("l5_hitack_cnt", 32'(frame_cnt), 0);
    step(0, 1, 0);
    chk("l5_ack", 32'(drop_req), 0);

    // Level 15 (clamped to 6): one overrun, then pause mid-request.
    level = 4'd15;
    ticks(12);
    chk("l15_miss", 32'(missed), 1);
    enable = 1'b0;
    step(1, 0, 0);
    chk("en_req", 32'(drop_req), 0);
    chk("en_cnt", 32'(frame_cnt), 0);
    ticks(4);
    chk("en_cnt5", 32'(frame_cnt), 0);
    chk("en_miss", 32'(missed), 1);
    resetn = 1'b0;
    enable = 1'b1;
    step(1, 0, 0);
    chk("rst2_req", 32'(drop_req), 0);
    chk("rst2_cnt", 32'(frame_cnt), 0);
    chk("rst2_miss", 32'(missed), 0);

    // 60 ticks at level 15, every request acked: exactly 10 drops.
    resetn = 1'b1;
    step(0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (drop_req === 1'b1) begin
        reqs++;
        step(1'b0, 1'b1, 1'b0);
      end
    end
    chk("l15_reqs", 32'(reqs), 10);
    chk("l15_miss0", 32'(missed), 0);
    chk("l15_cnt", 32'(frame_cnt), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
